// File: rtl/edge_filter_pkg.sv
// Shared types and defaults for the glitch-filtered edge detector.
// Combinational helpers only; no state, no flow control.
package edge_filter_pkg;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'b00,
        MODE_RISE = 2'b01,
        MODE_FALL = 2'b10,
        MODE_BOTH = 2'b11
    } mode_e;

    typedef enum logic {
        ST_LOW  = 1'b0,
        ST_HIGH = 1'b1
    } lvl_state_e;

    localparam int DEF_CHANNELS    = 4;
    localparam int DEF_HIGH_MIN    = 6;
    localparam int DEF_LOW_MIN     = 6;
    localparam int DEF_SYNC_STAGES = 2;

    // Run counter only has to reach THR-1, so clog2 of the larger threshold suffices.
    function automatic int cnt_width(input int hi, input int lo);
        int m;
        m = (hi > lo) ? hi : lo;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/edge_filter_detector_if.sv
// Control inputs and per-channel results of the edge detector, bundled.
// No handshake: outputs are single-cycle strobes with no backpressure.
interface edge_filter_detector_if
    import edge_filter_pkg::*;
#(
    parameter int CHANNELS = DEF_CHANNELS
);
    logic                en;
    mode_e               mode;
    logic [CHANNELS-1:0] din;
    logic [CHANNELS-1:0] level;
    logic [CHANNELS-1:0] pulse;
    logic [CHANNELS-1:0] glitch;
    logic                any_pulse;

    modport master (
        output en, mode, din,
        input  level, pulse, glitch, any_pulse
    );

    modport slave (
        input  en, mode, din,
        output level, pulse, glitch, any_pulse
    );
endinterface

// File: rtl/edge_filter_chan.sv
// One channel: synchroniser, run counter, debounced level, glitch strobe.
// Level settles SYNC_STAGES+THR edges after a stable change; no backpressure.
module edge_filter_chan
    import edge_filter_pkg::*;
#(
    parameter int HIGH_MIN    = DEF_HIGH_MIN,
    parameter int LOW_MIN     = DEF_LOW_MIN,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic din,
    output logic level,
    output logic glitch,
    output logic qual_rise,
    output logic qual_fall
);
    localparam int CW = cnt_width(HIGH_MIN, LOW_MIN);
    localparam logic [CW-1:0] HI_LAST = CW'(HIGH_MIN - 1);
    localparam logic [CW-1:0] LO_LAST = CW'(LOW_MIN - 1);

    if (HIGH_MIN < 1) begin : g_bad_high
        $error("HIGH_MIN must be >= 1");
    end
    if (LOW_MIN < 1) begin : g_bad_low
        $error("LOW_MIN must be >= 1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be >= 2");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    lvl_state_e             state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d, last;
    logic                   glitch_q, glitch_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_LOW;
            cnt_q    <= '0;
            glitch_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            glitch_q <= glitch_d;
        end
    end

    // Dropping en discards the run silently; it is not a glitch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        glitch_d  = 1'b0;
        qual_rise = 1'b0;
        qual_fall = 1'b0;
        last      = (state_q == ST_HIGH) ? LO_LAST : HI_LAST;
        if (!en) begin
            cnt_d = '0;
        end else if (s != (state_q == ST_HIGH)) begin
            if (cnt_q == last) begin
                state_d   = s ? ST_HIGH : ST_LOW;
                cnt_d     = '0;
                qual_rise = s;
                qual_fall = !s;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (cnt_q != '0) begin
            cnt_d    = '0;
            glitch_d = 1'b1;
        end
    end

    always_comb begin
        level  = (state_q == ST_HIGH);
        glitch = glitch_q;
    end

endmodule

// File: rtl/edge_filter_detector.sv
// Multi-channel debounced edge detector with run-time rise/fall/both selection.
// Pulse registered on the qualifying edge (SYNC_STAGES+THR after input); no backpressure.
module edge_filter_detector
    import edge_filter_pkg::*;
#(
    parameter int CHANNELS    = DEF_CHANNELS,
    parameter int HIGH_MIN    = DEF_HIGH_MIN,
    parameter int LOW_MIN     = DEF_LOW_MIN,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                   clk,
    input  logic                   reset_n,
    edge_filter_detector_if.slave  bus
);
    if (CHANNELS < 1) begin : g_bad_channels
        $error("CHANNELS must be >= 1");
    end

    logic [CHANNELS-1:0] level_w, glitch_w, qual_rise, qual_fall;
    logic [CHANNELS-1:0] pulse_d, pulse_q;
    logic                rise_sel, fall_sel;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        edge_filter_chan #(
            .HIGH_MIN    (HIGH_MIN),
            .LOW_MIN     (LOW_MIN),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_chan (
            .clk       (clk),
            .reset_n   (reset_n),
            .en        (bus.en),
            .din       (bus.din[i]),
            .level     (level_w[i]),
            .glitch    (glitch_w[i]),
            .qual_rise (qual_rise[i]),
            .qual_fall (qual_fall[i])
        );
    end

    // mode is applied to the same edge that qualifies the transition.
    always_comb begin
        rise_sel = (bus.mode == MODE_RISE) || (bus.mode == MODE_BOTH);
        fall_sel = (bus.mode == MODE_FALL) || (bus.mode == MODE_BOTH);
        pulse_d  = (qual_rise & {CHANNELS{rise_sel}}) | (qual_fall & {CHANNELS{fall_sel}});
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pulse_q <= '0;
        end else begin
            pulse_q <= pulse_d;
        end
    end

    assign bus.level     = level_w;
    assign bus.glitch    = glitch_w;
    assign bus.pulse     = pulse_q;
    assign bus.any_pulse = |pulse_q;

endmodule

// File: tb/tb_edge_filter_detector.sv
// Scoreboard bench: default build and a HIGH_MIN=1/LOW_MIN=3/SYNC_STAGES=3 build on shared stimulus.
module tb_edge_filter_detector;
    import edge_filter_pkg::*;

    localparam int CH   = 4;
    localparam int NDUT = 2;

    typedef struct packed {
        logic [CH-1:0] level;
        logic [CH-1:0] pulse;
        logic [CH-1:0] glitch;
        logic          any;
    } obs_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          en = 1'b1;
    logic [1:0]    mode_v = 2'b00;
    logic [CH-1:0] din = '0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    edge_filter_detector_if #(.CHANNELS(CH)) bus0 ();
    edge_filter_detector_if #(.CHANNELS(CH)) bus1 ();

    assign bus0.en   = en;
    assign bus0.mode = mode_e'(mode_v);
    assign bus0.din  = din;
    assign bus1.en   = en;
    assign bus1.mode = mode_e'(mode_v);
    assign bus1.din  = din;

    edge_filter_detector #(
        .CHANNELS(CH), .HIGH_MIN(6), .LOW_MIN(6), .SYNC_STAGES(2)
    ) u_dut0 (
        .clk(clk), .reset_n(reset_n), .bus(bus0)
    );

    edge_filter_detector #(
        .CHANNELS(CH), .HIGH_MIN(1), .LOW_MIN(3), .SYNC_STAGES(3)
    ) u_dut1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1)
    );

    function automatic int hmin(input int d);
        return (d == 0) ? 6 : 1;
    endfunction
    function automatic int lmin(input int d);
        return (d == 0) ? 6 : 3;
    endfunction
    function automatic int nsync(input int d);
        return (d == 0) ? 2 : 3;
    endfunction

    // Reference model: delayed input history plus "how long has it disagreed" per channel.
    bit            lvl_m [NDUT][CH];
    int            run_m [NDUT][CH];
    bit [CH-1:0]   hist0[$];
    bit [CH-1:0]   hist1[$];
    obs_t          exp_q0[$];
    obs_t          exp_q1[$];

    function automatic obs_t model_step(input int d, input bit [CH-1:0] s_vec);
        obs_t o;
        int   thr;
        o = '0;
        for (int c = 0; c < CH; c++) begin
            if (!en) begin
                run_m[d][c] = 0;
            end else if (s_vec[c] != lvl_m[d][c]) begin
                run_m[d][c]++;
                thr = lvl_m[d][c] ? lmin(d) : hmin(d);
                if (run_m[d][c] >= thr) begin
                    lvl_m[d][c] = s_vec[c];
                    run_m[d][c] = 0;
                    if ((s_vec[c] && mode_v[0]) || (!s_vec[c] && mode_v[1]))
                        o.pulse[c] = 1'b1;
                end
            end else if (run_m[d][c] != 0) begin
                run_m[d][c] = 0;
                o.glitch[c] = 1'b1;
            end
            o.level[c] = lvl_m[d][c];
        end
        o.any = |o.pulse;
        return o;
    endfunction

    always @(posedge clk) begin
        bit [CH-1:0] s0, s1;
        if (!reset_n) begin
            for (int d = 0; d < NDUT; d++)
                for (int c = 0; c < CH; c++) begin
                    lvl_m[d][c] = 1'b0;
                    run_m[d][c] = 0;
                end
            hist0.delete();
            hist1.delete();
            for (int k = 0; k < nsync(0); k++) hist0.push_back('0);
            for (int k = 0; k < nsync(1); k++) hist1.push_back('0);
            exp_q0.push_back('0);
            exp_q1.push_back('0);
        end else begin
            s0 = hist0.pop_front();
            hist0.push_back(din);
            s1 = hist1.pop_front();
            hist1.push_back(din);
            exp_q0.push_back(model_step(0, s0));
            exp_q1.push_back(model_step(1, s1));
        end
    end

    task automatic check(input string nm, input obs_t got, input obs_t want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s t=%0t got lvl=%b pul=%b gl=%b any=%b want lvl=%b pul=%b gl=%b any=%b",
                     nm, $time, got.level, got.pulse, got.glitch, got.any,
                     want.level, want.pulse, want.glitch, want.any);
        end
    endtask

    function automatic obs_t obs0();
        return {bus0.level, bus0.pulse, bus0.glitch, bus0.any_pulse};
    endfunction
    function automatic obs_t obs1();
        return {bus1.level, bus1.pulse, bus1.glitch, bus1.any_pulse};
    endfunction

    // Monitor: every cycle the DUTs present a result, pop and compare.
    always @(negedge clk) begin
        if (exp_q0.size() > 0) check("dut0_cycle", obs0(), exp_q0.pop_front());
        if (exp_q1.size() > 0) check("dut1_cycle", obs1(), exp_q1.pop_front());
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        tick(3);
        check("reset_dut0", obs0(), '0);
        check("reset_dut1", obs1(), '0);
        reset_n = 1'b1;

        // Fall-only mode, ch0 high then low.
        mode_v = 2'b10;
        din[0] = 1'b1; tick(20);
        din[0] = 1'b0; tick(20);

        // Both edges, 5-cycle excursion on ch1.
        mode_v = 2'b11;
        din[1] = 1'b1; tick(5);
        din[1] = 1'b0; tick(15);

        // Rise only, all channels together.
        mode_v = 2'b01;
        din = 4'hF; tick(15);
        din = 4'h0; tick(15);

        // en dropped mid-count on ch2.
        din[2] = 1'b1; tick(5);
        en = 1'b0; tick(10);
        en = 1'b1; tick(15);
        din[2] = 1'b0; tick(15);

        // Async reset mid-count on ch0.
        mode_v = 2'b11;
        din[0] = 1'b1; tick(6);
        @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("async_reset_dut0", obs0(), '0);
        check("async_reset_dut1", obs1(), '0);
        tick(2);
        reset_n = 1'b1;
        tick(20);
        din[0] = 1'b0; tick(15);

        // Short low excursion on ch3.
        din[3] = 1'b1; tick(10);
        din[3] = 1'b0; tick(2);
        din[3] = 1'b1; tick(10);
        din = '0; tick(15);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < CH; c++)
                if ($urandom_range(0, 5) == 0) din[c] = ~din[c];
            if ($urandom_range(0, 29) == 0) en = ~en;
            if ($urandom_range(0, 49) == 0) mode_v = 2'($urandom_range(0, 3));
            tick(1);
        end
        en = 1'b1;
        tick(5);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
